// File: rtl/lf_adder_pipe_if.sv
// Operand-issue / result handshake bundle for the pipelined Ladner-Fischer adder.
// The producer and consumer sides both use the master modport; the adder uses slave.
interface lf_adder_pipe_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output in_valid, a, b, cin, sub, tag_in, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, tag_out
  );

  modport slave (
    input  in_valid, a, b, cin, sub, tag_in, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, tag_out
  );
endinterface

// File: rtl/lf_adder_pipe.sv
// Pipelined Ladner-Fischer prefix adder/subtractor: input rank, g/p rank, S prefix ranks,
// output rank (latency S+2), with a single global advance used for backpressure.
module lf_adder_pipe #(
  parameter int WIDTH            = 64,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int TAG_W            = 4
) (
  input logic            clk,
  input logic            rst,
  lf_adder_pipe_if.slave bus
);
  localparam int N = $clog2(WIDTH);
  localparam int S = (N + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  typedef logic [WIDTH-1:0] word_t;

  // One prefix level: bits in the upper half of each 2^(lvl+1) block absorb the top bit of the lower half.
  function automatic logic [2*WIDTH-1:0] lf_level(input word_t g, input word_t pg, input int lvl);
    word_t go;
    word_t po;
    int    j;
    go = g;
    po = pg;
    for (int i = 0; i < WIDTH; i++) begin
      j = ((i >> (lvl + 1)) << (lvl + 1)) + (32'sd1 << lvl) - 32'sd1;
      if (((i >> lvl) & 32'sd1) == 32'sd1) begin
        go[i] = g[i] | (pg[i] & g[j]);
        po[i] = pg[i] & pg[j];
      end else begin
        go[i] = g[i];
        po[i] = pg[i];
      end
    end
    return {go, po};
  endfunction

  function automatic int lvl_end(input int s);
    return (s * LEVELS_PER_STAGE < N) ? s * LEVELS_PER_STAGE : N;
  endfunction

  logic             adv_s;
  logic             in_v_r;
  word_t            a_r;
  word_t            b_r;
  logic             ci_r;
  logic [TAG_W-1:0] tag_r;

  logic             v_r      [0:S];
  word_t            g_r      [0:S];
  word_t            pg_r     [0:S];
  word_t            p_r      [0:S];
  logic             ci_st_r  [0:S];
  logic [TAG_W-1:0] tag_st_r [0:S];

  word_t            p0_s;
  word_t            g_nx_s   [0:S];
  word_t            pg_nx_s  [0:S];
  word_t            sum_s;

  logic             out_valid_r;
  word_t            sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;
  logic [TAG_W-1:0] tag_out_r;

  assign adv_s        = ~out_valid_r | bus.out_ready;
  assign bus.in_ready = adv_s;
  assign bus.out_valid = out_valid_r;
  assign bus.sum      = sum_r;
  assign bus.cout     = cout_r;
  assign bus.ovf      = ovf_r;
  assign bus.zero     = zero_r;
  assign bus.tag_out  = tag_out_r;

  // Bitwise g/p with carry-in folded into bit 0, then the prefix levels of every stage.
  always_comb begin
    word_t gt;
    word_t pt;
    p0_s = a_r ^ b_r;
    gt = a_r & b_r;
    gt[0] = gt[0] | (p0_s[0] & ci_r);
    pt = p0_s;
    g_nx_s[0]  = gt;
    pg_nx_s[0] = pt;
    for (int s = 1; s <= S; s++) begin
      gt = g_r[s-1];
      pt = pg_r[s-1];
      for (int l = (s - 1) * LEVELS_PER_STAGE; l < lvl_end(s); l++) begin
        {gt, pt} = lf_level(gt, pt, l);
      end
      g_nx_s[s]  = gt;
      pg_nx_s[s] = pt;
    end
  end

  // c[0] is the effective carry-in; c[i] is the group generate of bits i-1..0.
  assign sum_s = p_r[S] ^ {g_r[S][WIDTH-2:0], ci_st_r[S]};

  // Whole pipe advances together; bubbles drive zeros onto the result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_v_r      <= 1'b0;
      for (int s = 0; s <= S; s++) begin
        v_r[s] <= 1'b0;
      end
      out_valid_r <= 1'b0;
      sum_r       <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
      tag_out_r   <= {TAG_W{1'b0}};
    end else if (adv_s) begin
      in_v_r <= bus.in_valid;
      a_r    <= bus.a;
      b_r    <= bus.b ^ {WIDTH{bus.sub}};
      ci_r   <= bus.sub | bus.cin;
      tag_r  <= bus.tag_in;

      v_r[0]      <= in_v_r;
      g_r[0]      <= g_nx_s[0];
      pg_r[0]     <= pg_nx_s[0];
      p_r[0]      <= p0_s;
      ci_st_r[0]  <= ci_r;
      tag_st_r[0] <= tag_r;
      for (int s = 1; s <= S; s++) begin
        v_r[s]      <= v_r[s-1];
        g_r[s]      <= g_nx_s[s];
        pg_r[s]     <= pg_nx_s[s];
        p_r[s]      <= p_r[s-1];
        ci_st_r[s]  <= ci_st_r[s-1];
        tag_st_r[s] <= tag_st_r[s-1];
      end

      out_valid_r <= v_r[S];
      if (v_r[S]) begin
        sum_r     <= sum_s;
        cout_r    <= g_r[S][WIDTH-1];
        ovf_r     <= g_r[S][WIDTH-1] ^ g_r[S][WIDTH-2];
        zero_r    <= (sum_s == {WIDTH{1'b0}});
        tag_out_r <= tag_st_r[S];
      end else begin
        sum_r     <= {WIDTH{1'b0}};
        cout_r    <= 1'b0;
        ovf_r     <= 1'b0;
        zero_r    <= 1'b0;
        tag_out_r <= {TAG_W{1'b0}};
      end
    end
  end
endmodule

// File: tb/tb_lf_adder_pipe.sv
// Scoreboard bench for lf_adder_pipe: 64-bit instance (latency 5) and an 8-bit instance
// with an uneven last prefix stage (latency 4).
module tb_lf_adder_pipe;
  localparam int W    = 64;
  localparam int LPS  = 2;
  localparam int TW   = 4;
  localparam int LAT  = 5;
  localparam int W8   = 8;
  localparam int LPS8 = 2;
  localparam int LAT8 = 4;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lf_adder_pipe_if #(.WIDTH(W),  .TAG_W(TW)) bus ();
  lf_adder_pipe_if #(.WIDTH(W8), .TAG_W(TW)) bus8 ();

  lf_adder_pipe #(.WIDTH(W), .LEVELS_PER_STAGE(LPS), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  lf_adder_pipe #(.WIDTH(W8), .LEVELS_PER_STAGE(LPS8), .TAG_W(TW)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8)
  );

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [3:0]  tag;
  } res_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [3:0]  tag;
    res_t        exp;
  } op_t;

  typedef struct {
    res_t exp;
    int   acc;
    bit   lat_chk;
  } sb_t;

  op_t stim[$];
  sb_t sb[$];
  sb_t sb8[$];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic cin,
                                 input logic sub, input int w, input logic [3:0] tag);
    res_t        r;
    logic [64:0] full;
    logic [63:0] mask;
    logic [63:0] am;
    logic [63:0] bx;
    mask   = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am     = a & mask;
    bx     = (sub ? ~b : b) & mask;
    full   = {1'b0, am} + {1'b0, bx} + {64'd0, (sub | cin)};
    r.sum  = full[63:0] & mask;
    r.cout = full[w];
    r.ovf  = (am[w-1] == bx[w-1]) && (r.sum[w-1] != am[w-1]);
    r.zero = (r.sum == 64'd0);
    r.tag  = tag;
    return r;
  endfunction

  function automatic op_t mk(input logic [63:0] a, input logic [63:0] b, input logic cin,
                             input logic sub, input logic [3:0] tag, input logic [63:0] s,
                             input logic co, input logic ov, input logic z);
    op_t o;
    o.a = a; o.b = b; o.cin = cin; o.sub = sub; o.tag = tag;
    o.exp.sum = s; o.exp.cout = co; o.exp.ovf = ov; o.exp.zero = z; o.exp.tag = tag;
    return o;
  endfunction

  // Monitor for the 64-bit instance: pops on each retirement, checks freeze while stalled.
  initial begin
    res_t got;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && bus.out_valid) begin
        got.sum = bus.sum; got.cout = bus.cout; got.ovf = bus.ovf;
        got.zero = bus.zero; got.tag = bus.tag_out;
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", bus.out_valid, 1'b0);
        end else if (bus.out_ready) begin
          chk("result", got, sb[0].exp);
          if (sb[0].lat_chk) chk("latency", cyc - sb[0].acc, LAT);
          void'(sb.pop_front());
        end else begin
          chk("stall_hold", got, sb[0].exp);
          chk("stall_in_ready", bus.in_ready, 1'b0);
        end
      end
    end
  end

  // Monitor for the 8-bit instance (always ready).
  initial begin
    res_t got8;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && bus8.out_valid) begin
        got8.sum = {56'd0, bus8.sum}; got8.cout = bus8.cout; got8.ovf = bus8.ovf;
        got8.zero = bus8.zero; got8.tag = bus8.tag_out;
        if (sb8.size() == 0) begin
          chk("w8_unexpected_out_valid", bus8.out_valid, 1'b0);
        end else begin
          chk("w8_result", got8, sb8[0].exp);
          chk("w8_latency", cyc - sb8[0].acc, LAT8);
          void'(sb8.pop_front());
        end
      end
    end
  end

  task automatic run(input int stall_at, input int stall_len, input bit lat_chk, input bit rnd);
    int  t = 0;
    bit  acc;
    sb_t e;
    while (stim.size() > 0 && t < 2000) begin
      bus.out_ready = rnd ? ($urandom_range(0, 9) < 7) : !(t >= stall_at && t < stall_at + stall_len);
      bus.in_valid  = rnd ? ($urandom_range(0, 9) < 8) : 1'b1;
      bus.a = stim[0].a; bus.b = stim[0].b; bus.cin = stim[0].cin;
      bus.sub = stim[0].sub; bus.tag_in = stim[0].tag;
      #1;
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (acc) begin
        e.exp = stim[0].exp; e.acc = cyc + 1; e.lat_chk = lat_chk;
        sb.push_back(e);
        void'(stim.pop_front());
      end
      @(negedge clk);
      t++;
    end
    chk("issue_done", stim.size(), 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic drain();
    int k = 0;
    while ((sb.size() > 0 || sb8.size() > 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("drain", sb.size() + sb8.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rc;
    logic        rs;
    sb_t         e8;
    bit          acc8;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.a = '0; bus.b = '0;
    bus.cin = 1'b0; bus.sub = 1'b0; bus.tag_in = '0;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b1; bus8.a = '0; bus8.b = '0;
    bus8.cin = 1'b0; bus8.sub = 1'b0; bus8.tag_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #3;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_outputs", {bus.sum, bus.cout, bus.ovf, bus.zero, bus.tag_out}, 0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);

    // Directed vectors, latency checked.
    stim.push_back(mk(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 4'd3, 64'd0, 1'b1, 1'b0, 1'b1));
    stim.push_back(mk(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 4'd4, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0));
    stim.push_back(mk(64'd5, 64'd7, 1'b1, 1'b1, 4'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0));
    stim.push_back(mk(64'd7, 64'd5, 1'b0, 1'b1, 4'd6, 64'd2, 1'b1, 1'b0, 1'b0));
    stim.push_back(mk(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 4'd7, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0));
    stim.push_back(mk(64'd5, 64'd5, 1'b0, 1'b1, 4'd8, 64'd0, 1'b1, 1'b0, 1'b1));
    stim.push_back(mk(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 4'd9, 64'd0, 1'b1, 1'b1, 1'b1));
    stim.push_back(mk(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 4'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0));
    stim.push_back(mk(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, 4'd11, 64'd0, 1'b1, 1'b0, 1'b1));
    run(1000, 0, 1'b1, 1'b0);
    drain();

    // Back-to-back throughput: results on consecutive cycles at fixed latency.
    for (int i = 0; i < 8; i++) begin
      stim.push_back(mk(64'(i), 64'(i) << 32, 1'b0, 1'b0, 4'(i), 64'(i) + (64'(i) << 32), 1'b0, 1'b0, (i == 0)));
    end
    run(1000, 0, 1'b1, 1'b0);
    drain();

    // Backpressure: 4-cycle stall while results are pending.
    for (int i = 1; i <= 6; i++) begin
      stim.push_back(mk(64'(i * 100), 64'd1, 1'b0, 1'b1, 4'(i), 64'(i * 100 - 1), 1'b1, 1'b0, 1'b0));
    end
    run(6, 4, 1'b0, 1'b0);
    drain();

    // Reset in flight: three operations issued, reset on the third; nothing may emerge.
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.a = 64'd1; bus.b = 64'd2; bus.cin = 1'b0; bus.sub = 1'b0; bus.tag_in = 4'd1;
    @(posedge clk); @(negedge clk);
    bus.a = 64'd3; bus.b = 64'd4; bus.tag_in = 4'd2;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    bus.a = 64'd5; bus.b = 64'd6; bus.tag_in = 4'd3;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      #3;
      chk("postrst_out_valid", bus.out_valid, 1'b0);
      chk("postrst_outputs", {bus.sum, bus.cout, bus.ovf, bus.zero, bus.tag_out}, 0);
      chk("postrst_in_ready", bus.in_ready, 1'b1);
      @(negedge clk);
    end

    // Random operands with random backpressure and input bubbles against the reference model.
    for (int i = 0; i < 60; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      stim.push_back(mk(ra, rb, rc, rs, 4'(i), 64'd0, 1'b0, 1'b0, 1'b0));
      stim[$].exp = model(ra, rb, rc, rs, W, 4'(i));
    end
    run(0, 0, 1'b0, 1'b1);
    drain();

    // 8-bit instance, uneven final prefix stage, streamed every cycle.
    for (int i = 0; i < 300; i++) begin
      ra = 64'($urandom_range(0, 255)); rb = 64'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      bus8.in_valid = 1'b1; bus8.a = ra[7:0]; bus8.b = rb[7:0];
      bus8.cin = rc; bus8.sub = rs; bus8.tag_in = 4'(i);
      #1;
      acc8 = bus8.in_ready;
      @(posedge clk);
      if (acc8) begin
        e8.exp = model(ra, rb, rc, rs, W8, 4'(i)); e8.acc = cyc + 1; e8.lat_chk = 1'b1;
        sb8.push_back(e8);
      end
      @(negedge clk);
    end
    bus8.in_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lf_adder_pipe.md
Name: lf_adder_pipe

Overview:
- Parametrised, pipelined Ladner-Fischer parallel-prefix adder/subtractor.
- Generalises the fixed-width combinational prefix carry networks to any power-of-two WIDTH, with configurable register insertion between prefix levels.
- Adds carry-in, a subtract mode, a valid/ready handshake with backpressure, a tag passthrough, and result flags.
- Sits as the integer add datapath behind operand-issue logic.

Parameters:
- WIDTH, 64, operand width; power of two, 8..128.
- LEVELS_PER_STAGE, 2, prefix levels evaluated between pipeline registers; 1..log2(WIDTH).
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept an operand set this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b (computed as a+~b+1).
- tag_in  input  TAG_W  tag, returned unchanged with the result.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow = c[WIDTH] ^ c[WIDTH-1].
- zero  output  1  sum == 0.
- tag_out  output  TAG_W  tag of the current result.

Behaviour:
- Definitions: N = log2(WIDTH); S = ceil(N/LEVELS_PER_STAGE); LAT = S+2.
- Stage 0 (input register):
  - Captures a, b^{WIDTH{sub}}, effective carry-in (sub ? 1 : cin), and tag.
  - Computes bitwise g = a&b' and p = a^b'.
  - Carry-in is folded in as g[-1]: g0' = g0 | (p0 & cin_eff).
- Prefix stages 1..S:
  - Ladner-Fischer levels; level k combines each block of 2^k with the top bit of the lower half.
  - Operators: G = Gh | (Ph & Gl), P = Ph & Pl.
  - A register follows every LEVELS_PER_STAGE levels; the last stage may hold fewer levels.
  - Bitwise p and the tag are carried alongside to each stage.
- Output stage: sum[i] = p[i] ^ c[i], where c[0] = cin_eff and c[i] = group G[i-1:0]. Registers sum, cout, ovf, zero, and tag_out.
- Latency: an operand set accepted at edge k appears on the outputs with out_valid=1 after edge k+LAT. Default LAT = 5 (WIDTH=64, LEVELS_PER_STAGE=2).
- Handshake:
  - Global advance: adv = ~out_valid | out_ready. in_ready = adv (combinational from out_valid and out_ready only).
  - A transfer occurs on in_valid & in_ready.
  - Each stage carries a valid bit. On adv, every stage loads its predecessor and stage 0 loads in_valid; otherwise all stages hold.
  - Bubbles are not collapsed.
- Throughput: one operation per cycle while out_ready=1.
- Stall: with out_valid=1 and out_ready=0, all outputs, including sum and the flags, are held stable. No operation is lost or duplicated.
- Reset:
  - All valid bits cleared; out_valid=0; sum=0; cout=0; ovf=0; zero=0; tag_out=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight operations; no partial result emerges.
  - Datapath registers other than the outputs need not be cleared.
- Arithmetic is modulo 2^WIDTH.
- Subtract: cout=1 means no borrow (a >= b unsigned). ovf is valid for the signed interpretation in both modes.
- Simultaneous out_ready=1 and in_valid=1 while the pipe is full: the output retires and the input is accepted in the same edge.

Test Plan:
- Add, WIDTH=64: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1, sub=0, tag=3 -> after 5 cycles: sum=0, cout=1, zero=1, ovf=0, tag_out=3.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=0x8000_0000_0000_0000, ovf=1, cout=0. Subtract a=5, b=7, sub=1, cin=1 (ignored) -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
- Back-to-back throughput: 8 consecutive ops (a=i, b=i<<32, tag=i) with out_ready=1 -> results on 8 consecutive cycles starting at LAT, in order, sum=i+(i<<32).
- Backpressure: stream 6 ops and hold out_ready=0 for 4 cycles mid-stream -> in_ready=0 during the stall, outputs frozen, all 6 results delivered once each, in order.
- Reset mid-flight: accept 3 ops, assert rst for one cycle at cycle 2 -> out_valid stays 0 for the next LAT+2 cycles, all outputs are 0, in_ready=1.
- Parameter sweep: WIDTH=8/32/128 with LEVELS_PER_STAGE=1/3/N -> LAT = ceil(N/LPS)+2. 10k random ops match the reference model a+b+cin and a-b on sum/cout/ovf/zero.
